// File: rtl/mcs4_phase_sequencer.sv
// Master timing sequencer for a 4004 core. It derives the two-phase clk1/clk2 enables,
// the one-hot subcycle and sync from sysclk, and adds run/halt/single-step control.
module mcs4_phase_sequencer #(
    parameter int PERIOD   = 8,
    parameter int C1_W     = 2,
    parameter int C2_START = 4,
    parameter int C2_W     = 2,
    parameter int CNT_W    = 16
) (
    input  logic             sysclk,
    input  logic             poc_n,
    input  logic             run,
    input  logic             step_req,
    output logic             clk1,
    output logic             clk2,
    output logic [7:0]       sub,
    output logic             sync,
    output logic             halted,
    output logic             step_ack,
    output logic [CNT_W-1:0] icount
);

    localparam int TW = $clog2(PERIOD);
    localparam logic [TW-1:0] LAST_TICK = TW'(PERIOD - 1);
    localparam logic [TW-1:0] C1_END    = TW'(C1_W);
    localparam logic [TW-1:0] C2_LO     = TW'(C2_START);
    localparam logic [TW-1:0] C2_HI     = TW'(C2_START + C2_W);

    if (PERIOD < 4 || PERIOD > 64) begin : g_bad_period
        $error("mcs4_phase_sequencer: PERIOD must be within 4..64");
    end
    if (C1_W < 1 || C2_START <= C1_W) begin : g_bad_c1
        $error("mcs4_phase_sequencer: need C1_W >= 1 and C2_START > C1_W");
    end
    if (C2_W < 1 || C2_START + C2_W > PERIOD - 1) begin : g_bad_c2
        $error("mcs4_phase_sequencer: need C2_W >= 1 and C2_START+C2_W <= PERIOD-1");
    end

    typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  icount_q, icount_d;
    logic              step_prev_q;
    logic              clk1_q, clk1_d;
    logic              clk2_q, clk2_d;
    logic [7:0]        sub_q, sub_d;
    logic              sync_q, sync_d;
    logic              halted_q, halted_d;
    logic              step_ack_q, step_ack_d;
    logic              step_edge;
    logic              last_tick;
    logic              active_d;

    assign step_edge = step_req & ~step_prev_q;
    assign last_tick = (tick_q == LAST_TICK) && (idx_q == 3'd7);

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        idx_d    = idx_q;
        icount_d = icount_q;
        case (state_q)
            S_HALT: begin
                tick_d = '0;
                idx_d  = '0;
                if (run) begin
                    state_d = S_RUN;
                end else if (step_edge) begin
                    state_d = S_STEP;
                end
            end
            default: begin
                if (tick_q == LAST_TICK) begin
                    tick_d = '0;
                    idx_d  = idx_q + 3'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
                // Halt decisions are only taken on the instruction boundary so phases never truncate.
                if (last_tick) begin
                    icount_d = icount_q + 1'b1;
                    if (state_q == S_STEP || !run) begin
                        state_d = S_HALT;
                    end
                end
            end
        endcase

        // Outputs are registered from the next-state values so they line up with the tick they describe.
        active_d   = (state_d != S_HALT);
        clk1_d     = active_d && (tick_d < C1_END);
        clk2_d     = active_d && (tick_d >= C2_LO) && (tick_d < C2_HI);
        sub_d      = active_d ? (8'b1 << idx_d) : 8'b0;
        sync_d     = active_d && (idx_d == 3'd7);
        halted_d   = !active_d;
        step_ack_d = (state_d == S_STEP) && (tick_d == LAST_TICK) && (idx_d == 3'd7);
    end

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            state_q     <= S_HALT;
            tick_q      <= '0;
            idx_q       <= '0;
            icount_q    <= '0;
            // Preset high so a step_req already asserted at release is not seen as an edge.
            step_prev_q <= 1'b1;
            clk1_q      <= 1'b0;
            clk2_q      <= 1'b0;
            sub_q       <= 8'b0;
            sync_q      <= 1'b0;
            halted_q    <= 1'b1;
            step_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            idx_q       <= idx_d;
            icount_q    <= icount_d;
            step_prev_q <= step_req;
            clk1_q      <= clk1_d;
            clk2_q      <= clk2_d;
            sub_q       <= sub_d;
            sync_q      <= sync_d;
            halted_q    <= halted_d;
            step_ack_q  <= step_ack_d;
        end
    end

    assign clk1     = clk1_q;
    assign clk2     = clk2_q;
    assign sub      = sub_q;
    assign sync     = sync_q;
    assign halted   = halted_q;
    assign step_ack = step_ack_q;
    assign icount   = icount_q;

endmodule

// File: tb/tb_mcs4_phase_sequencer.sv
// Bench for mcs4_phase_sequencer: a position-within-instruction-cycle reference model
// is advanced every sysclk and compared against all outputs on the falling edge.
module tb_mcs4_phase_sequencer;

    localparam int P     = 8;
    localparam int C1W   = 2;
    localparam int C2S   = 4;
    localparam int C2W   = 2;
    localparam int CNT_W = 6;
    localparam int OW    = 13 + CNT_W;
    localparam logic [OW-1:0] RST_VEC = {11'b0, 1'b1, 1'b0, {CNT_W{1'b0}}};

    logic             sysclk = 1'b0;
    logic             poc_n = 1'b0;
    logic             run = 1'b0;
    logic             step_req = 1'b0;
    logic             clk1, clk2, sync, halted, step_ack;
    logic [7:0]       sub;
    logic [CNT_W-1:0] icount;
    logic [OW-1:0]    obs;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: one position counter 0..8P-1 per instruction cycle.
    logic             m_active;
    logic             m_step;
    int               m_pos;
    logic [CNT_W-1:0] m_icount;
    logic             m_prev;

    mcs4_phase_sequencer #(
        .PERIOD(P), .C1_W(C1W), .C2_START(C2S), .C2_W(C2W), .CNT_W(CNT_W)
    ) dut (
        .sysclk(sysclk), .poc_n(poc_n), .run(run), .step_req(step_req),
        .clk1(clk1), .clk2(clk2), .sub(sub), .sync(sync), .halted(halted),
        .step_ack(step_ack), .icount(icount)
    );

    always #5 sysclk = ~sysclk;

    assign obs = {clk1, clk2, sub, sync, halted, step_ack, icount};

    task automatic model_reset();
        m_active = 1'b0;
        m_step   = 1'b0;
        m_pos    = 0;
        m_icount = '0;
        m_prev   = 1'b1;
    endtask

    function automatic logic [OW-1:0] exp_vec();
        int         t;
        int         s;
        logic       e1, e2, es, eack;
        logic [7:0] esub;
        t    = m_pos % P;
        s    = m_pos / P;
        e1   = m_active && (t < C1W);
        e2   = m_active && (t >= C2S) && (t < C2S + C2W);
        esub = m_active ? (8'b1 << s) : 8'b0;
        es   = m_active && (s == 7);
        eack = m_active && m_step && (m_pos == 8 * P - 1);
        return {e1, e2, esub, es, !m_active, eack, m_icount};
    endfunction

    // Advance one sysclk: model follows the inputs sampled at the rising edge; returns at the falling edge.
    task automatic tick_model();
        @(posedge sysclk);
        if (!poc_n) begin
            model_reset();
        end else begin
            if (!m_active) begin
                if (run) begin
                    m_active = 1'b1; m_step = 1'b0; m_pos = 0;
                end else if (step_req && !m_prev) begin
                    m_active = 1'b1; m_step = 1'b1; m_pos = 0;
                end
            end else if (m_pos == 8 * P - 1) begin
                m_icount = m_icount + 1'b1;
                m_pos = 0;
                if (m_step || !run) begin
                    m_active = 1'b0;
                    m_step   = 1'b0;
                end
            end else begin
                m_pos++;
            end
            m_prev = step_req;
        end
        @(negedge sysclk);
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < 3; i++) tick_model();
        tests_run++;
        if (obs !== RST_VEC) begin
            tests_failed++;
            $display("FAIL reset_in: got %h want %h", obs, RST_VEC);
        end
        poc_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick_model();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_free_run();
        run = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i == 150) run = 1'b0;
            tick_model();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL free_run cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_run_drop();
        int active_cycles = 0;
        run = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick_model();
            if (m_active && m_pos == 3 * P + 2) run = 1'b0;
            if (sub != 8'b0) active_cycles++;
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL run_drop cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        tests_run++;
        if (active_cycles !== 64) begin
            tests_failed++;
            $display("FAIL run_drop_len: got %0d active cycles want 64", active_cycles);
        end
    endtask

    task automatic test_step();
        int acks = 0;
        step_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick_model();
            if (step_ack) acks++;
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL step cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        step_req = 1'b0;
        tests_run++;
        if (acks !== 1) begin
            tests_failed++;
            $display("FAIL step_ack_count: got %0d want 1", acks);
        end
    endtask

    task automatic test_step_in_run();
        int acks = 0;
        run = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick_model();
            if (m_active && m_pos == 5 * P) step_req = 1'b1;
            if (m_active && m_pos == 6 * P) run = 1'b0;
            if (step_ack) acks++;
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL step_in_run cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        step_req = 1'b0;
        tests_run++;
        if (acks !== 0) begin
            tests_failed++;
            $display("FAIL step_in_run_ack: got %0d acks want 0", acks);
        end
    endtask

    task automatic test_wrap();
        logic [CNT_W-1:0] start;
        start = m_icount;
        run = 1'b1;
        for (int i = 0; i < (1 << CNT_W) * 8 * P + 1; i++) begin
            tick_model();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL wrap cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        tests_run++;
        if (icount !== start) begin
            tests_failed++;
            $display("FAIL wrap_icount: got %0d want %0d", icount, start);
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        run = 1'b1;
        while (!(m_active && m_pos == 2 * P + 3) && guard < 200) begin
            tick_model();
            guard++;
        end
        tests_run++;
        if (guard >= 200) begin
            tests_failed++;
            $display("FAIL async_reach: got no A3 tick 3 within %0d cycles", guard);
        end
        #1 poc_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (obs !== RST_VEC) begin
            tests_failed++;
            $display("FAIL async_reset: got %h want %h", obs, RST_VEC);
        end
        run = 1'b0;
        step_req = 1'b1;
        for (int i = 0; i < 3; i++) tick_model();
        poc_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick_model();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL async_release cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        step_req = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 99) < 2) run = ~run;
            if ($urandom_range(0, 99) < 4) step_req = ~step_req;
            tick_model();
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        @(negedge sysclk);
        test_reset();
        test_free_run();
        test_run_drop();
        test_step();
        test_step_in_run();
        test_wrap();
        run = 1'b0;
        for (int i = 0; i < 70; i++) tick_model();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
